// File: rtl/mm2s_readback_checker.sv
// MM2S read-back checker: paces tready to one beat per RATE_DIV cycles and checks
// each beat against an incrementing pattern, tlast placement, and tkeep.
module mm2s_readback_checker #(
   parameter int W        = 64,
   parameter int RATE_DIV = 8,
   parameter int CNT_W    = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [W-1:0]     i_seed,
   input  logic [CNT_W-1:0] i_length,
   input  logic [W-1:0]     i_s_axis_tdata,
   input  logic [W/8-1:0]   i_s_axis_tkeep,
   input  logic             i_s_axis_tlast,
   input  logic             i_s_axis_tvalid,
   output logic             o_s_axis_tready,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_word_count,
   output logic [CNT_W-1:0] o_err_count,
   output logic             o_err_flag,
   output logic             o_tlast_err,
   output logic [CNT_W-1:0] o_first_err_index,
   output logic [W-1:0]     o_first_err_data
);

   localparam int PACE_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(RATE_DIV - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_done_nxt;
   logic               r_done;
   logic [PACE_W-1:0]  r_pace;
   logic [W-1:0]       r_expected;
   logic [CNT_W-1:0]   r_remaining;
   logic [CNT_W-1:0]   r_word_count;
   logic [CNT_W-1:0]   r_err_count;
   logic               r_err_flag;
   logic               r_tlast_err;
   logic [CNT_W-1:0]   r_first_err_index;
   logic [W-1:0]       r_first_err_data;

   logic w_tready;
   logic w_hs;
   logic w_beat_err;
   logic w_final;
   logic w_tlast_bad;

   // tready depends only on registered state, never on tvalid
   assign w_tready    = (r_state == S_RUN) && (r_pace == '0);
   assign w_hs        = w_tready && i_s_axis_tvalid;
   assign w_beat_err  = (i_s_axis_tdata != r_expected) || (i_s_axis_tkeep != '1);
   assign w_final     = (r_remaining == CNT_W'(1)) || i_s_axis_tlast;
   assign w_tlast_bad = (i_s_axis_tlast && (r_remaining > CNT_W'(1))) ||
                        ((r_remaining == CNT_W'(1)) && !i_s_axis_tlast);

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (i_length != '0) w_state_nxt = S_RUN;
               else                w_done_nxt  = 1'b1;
            end
         end
         S_RUN: begin
            if (w_hs && w_final) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pace            <= '0;
         r_expected        <= '0;
         r_remaining       <= '0;
         r_word_count      <= '0;
         r_err_count       <= '0;
         r_err_flag        <= 1'b0;
         r_tlast_err       <= 1'b0;
         r_first_err_index <= '0;
         r_first_err_data  <= '0;
      end else if (r_state == S_IDLE) begin
         if (i_start) begin
            r_word_count      <= '0;
            r_err_count       <= '0;
            r_err_flag        <= 1'b0;
            r_tlast_err       <= 1'b0;
            r_first_err_index <= '0;
            r_first_err_data  <= '0;
            if (i_length != '0) begin
               r_expected  <= i_seed;
               r_remaining <= i_length;
               r_pace      <= PACE_RELOAD;
            end
         end
      end else if (w_hs) begin
         r_pace       <= PACE_RELOAD;
         r_expected   <= r_expected + W'(1);
         r_word_count <= r_word_count + CNT_W'(1);
         r_remaining  <= r_remaining - CNT_W'(1);
         if (w_beat_err) begin
            if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
            // err_count never returns to zero within a run, so zero marks the first error
            if (r_err_count == '0) begin
               r_first_err_index <= r_word_count;
               r_first_err_data  <= i_s_axis_tdata;
            end
         end
         if (w_tlast_bad) r_tlast_err <= 1'b1;
         if (w_beat_err || w_tlast_bad) r_err_flag <= 1'b1;
      end else if (r_pace != '0) begin
         r_pace <= r_pace - PACE_W'(1);
      end
   end

   assign o_s_axis_tready   = w_tready;
   assign o_busy            = (r_state == S_RUN);
   assign o_done            = r_done;
   assign o_word_count      = r_word_count;
   assign o_err_count       = r_err_count;
   assign o_err_flag        = r_err_flag;
   assign o_tlast_err       = r_tlast_err;
   assign o_first_err_index = r_first_err_index;
   assign o_first_err_data  = r_first_err_data;

endmodule

// File: tb/tb_mm2s_readback_checker.sv
// Bench for mm2s_readback_checker: table of stream scenarios on a RATE_DIV=8 and a
// RATE_DIV=1 instance, plus hand-written reset / length-0 / start-collision sequences.
module tb_mm2s_readback_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        sel;
   logic [63:0] seed;
   logic [31:0] length;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        tvalid;

   logic        tready8, busy8, done8, flag8, tle8;
   logic [31:0] wc8, ec8, fei8;
   logic [63:0] fed8;
   logic        tready1, busy1, done1, flag1, tle1;
   logic [31:0] wc1, ec1, fei1;
   logic [63:0] fed1;

   logic        tready, busy, done, eflag, tle;
   logic [31:0] wc, ec, fei;
   logic [63:0] fed;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mm2s_readback_checker #(.W(64), .RATE_DIV(8), .CNT_W(32)) dut8 (
      .i_clk(clk), .i_reset(reset), .i_start(start && !sel), .i_seed(seed), .i_length(length),
      .i_s_axis_tdata(tdata), .i_s_axis_tkeep(tkeep), .i_s_axis_tlast(tlast),
      .i_s_axis_tvalid(tvalid && !sel), .o_s_axis_tready(tready8), .o_busy(busy8), .o_done(done8),
      .o_word_count(wc8), .o_err_count(ec8), .o_err_flag(flag8), .o_tlast_err(tle8),
      .o_first_err_index(fei8), .o_first_err_data(fed8));

   mm2s_readback_checker #(.W(64), .RATE_DIV(1), .CNT_W(32)) dut1 (
      .i_clk(clk), .i_reset(reset), .i_start(start && sel), .i_seed(seed), .i_length(length),
      .i_s_axis_tdata(tdata), .i_s_axis_tkeep(tkeep), .i_s_axis_tlast(tlast),
      .i_s_axis_tvalid(tvalid && sel), .o_s_axis_tready(tready1), .o_busy(busy1), .o_done(done1),
      .o_word_count(wc1), .o_err_count(ec1), .o_err_flag(flag1), .o_tlast_err(tle1),
      .o_first_err_index(fei1), .o_first_err_data(fed1));

   assign tready = sel ? tready1 : tready8;
   assign busy   = sel ? busy1   : busy8;
   assign done   = sel ? done1   : done8;
   assign eflag  = sel ? flag1   : flag8;
   assign tle    = sel ? tle1    : tle8;
   assign wc     = sel ? wc1     : wc8;
   assign ec     = sel ? ec1     : ec8;
   assign fei    = sel ? fei1    : fei8;
   assign fed    = sel ? fed1    : fed8;

   typedef struct {
      bit          sel;
      logic [63:0] seed;
      int          len;
      int          tlast_idx;
      logic [31:0] derr_mask;
      logic [31:0] kerr_mask;
      int          stall_beat;
      int          stall_len;
      int          restart_cyc;
      int          exp_wc;
      int          exp_ec;
      int          exp_fei;
      logic [63:0] exp_fed;
      bit          exp_tle;
      bit          exp_flag;
   } vec_t;

   vec_t tbl[8];

   function automatic vec_t mk(bit s, logic [63:0] sd, int ln, int tl, logic [31:0] dm,
                               logic [31:0] km, int sb, int sl, int rc, int ewc, int eec,
                               int efei, logic [63:0] efed, bit etle, bit eflg);
      vec_t v;
      v.sel = s; v.seed = sd; v.len = ln; v.tlast_idx = tl; v.derr_mask = dm;
      v.kerr_mask = km; v.stall_beat = sb; v.stall_len = sl; v.restart_cyc = rc;
      v.exp_wc = ewc; v.exp_ec = eec; v.exp_fei = efei; v.exp_fed = efed;
      v.exp_tle = etle; v.exp_flag = eflg;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int hs[$];
      int beat = 0, cyc = 0, done_cnt = 0, done_cyc = -1, stall_cnt = 0, post = 0;
      int rate, gap;
      string tag;
      tag = $sformatf("v%0d", id);
      rate = v.sel ? 1 : 8;
      sel = v.sel; seed = v.seed; length = 32'(v.len); start = 1'b1;
      tvalid = 1'b0;
      tick();
      start = 1'b0;
      chk({tag, "_busy_start"}, busy, 1);
      while (cyc < 600 && post < 12) begin
         tvalid = !(beat == v.stall_beat && stall_cnt < v.stall_len);
         if (beat == v.stall_beat && stall_cnt < v.stall_len) stall_cnt++;
         tdata = v.seed + 64'(beat);
         if (beat < 32 && v.derr_mask[beat]) tdata = tdata ^ 64'h1;
         tkeep = (beat < 32 && v.kerr_mask[beat]) ? 8'h7F : 8'hFF;
         tlast = (beat == v.tlast_idx);
         start = (cyc == v.restart_cyc);
         if (start) begin seed = 64'hDEAD; length = 32'd2; end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (done_cyc >= 0) post++;
         if (tvalid && tready) begin hs.push_back(cyc); beat++; end
         tick();
         cyc++;
      end
      tvalid = 1'b0; start = 1'b0; tlast = 1'b0;
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_handshakes"}, hs.size(), v.exp_wc);
      if (hs.size() > 0) begin
         chk({tag, "_first_hs_cycle"}, hs[0], rate - 1);
         chk({tag, "_done_cycle"}, done_cyc, hs[hs.size()-1] + 1);
      end
      for (int i = 1; i < hs.size(); i++) begin
         gap = rate;
         if (i == v.stall_beat && v.stall_len + 1 > rate) gap = v.stall_len + 1;
         chk($sformatf("%s_gap%0d", tag, i), hs[i] - hs[i-1], gap);
      end
      chk({tag, "_word_count"}, wc, v.exp_wc);
      chk({tag, "_err_count"}, ec, v.exp_ec);
      chk({tag, "_first_err_index"}, fei, v.exp_fei);
      chk({tag, "_first_err_data"}, fed, v.exp_fed);
      chk({tag, "_tlast_err"}, tle, v.exp_tle);
      chk({tag, "_err_flag"}, eflag, v.exp_flag);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_tready_end"}, tready, 0);
   endtask

   initial begin
      int beat, cyc, dcnt;
      //            sel seed                    len tl  derr   kerr   sb  sl  rc  wc ec fei fed    tle flg
      tbl[0] = mk(0, 64'h10,                  16, 15, 32'h0, 32'h0, -1, 0, -1, 16, 0, 0, 64'h0,  0, 0);
      tbl[1] = mk(0, 64'h10,                  16, 15, 32'h20,32'h0, -1, 0, -1, 16, 1, 5, 64'h14, 0, 1);
      tbl[2] = mk(0, 64'h10,                  16,  9, 32'h0, 32'h0, -1, 0, -1, 10, 0, 0, 64'h0,  1, 1);
      tbl[3] = mk(0, 64'h10,                  16, 15, 32'h0, 32'h0,  4, 20,-1, 16, 0, 0, 64'h0,  0, 0);
      tbl[4] = mk(0, 64'h100,                  4, -1, 32'h0, 32'hC, -1, 0, -1,  4, 2, 2, 64'h102,1, 1);
      tbl[5] = mk(0, 64'h40,                   6,  5, 32'h0, 32'h0, -1, 0, 10,  6, 0, 0, 64'h0,  0, 0);
      tbl[6] = mk(1, 64'hFFFF_FFFF_FFFF_FFFE,  4,  3, 32'h0, 32'h0, -1, 0, -1,  4, 0, 0, 64'h0,  0, 0);
      tbl[7] = mk(1, 64'h55,                   3,  2, 32'h5, 32'h0, -1, 0, -1,  3, 2, 0, 64'h54, 0, 1);

      reset = 1'b1; start = 1'b0; sel = 1'b0; seed = '0; length = '0;
      tdata = '0; tkeep = 8'hFF; tlast = 1'b0; tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {busy8, busy1}, 0);
      chk("rst_tready", {tready8, tready1}, 0);
      chk("rst_done", {done8, done1}, 0);
      chk("rst_counts", {wc8, ec8}, 0);
      chk("rst_flags", {flag8, tle8, fei8}, 0);
      chk("rst_fed", fed8 | fed1, 0);
      reset = 1'b0;
      tick();

      foreach (tbl[i]) begin
         run_vec(tbl[i], i);
         repeat (2) tick();
      end

      // reset in the middle of a run
      sel = 1'b0; seed = 64'h0; length = 32'd16; start = 1'b1;
      tick();
      start = 1'b0;
      beat = 0; cyc = 0;
      while (beat < 4 && cyc < 200) begin
         tvalid = 1'b1; tdata = 64'(beat); tkeep = 8'hFF; tlast = 1'b0;
         if (tready) beat++;
         tick();
         cyc++;
      end
      chk("mid_beats_before_reset", wc, 4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_tready", tready, 0);
      chk("mid_rst_word_count", wc, 0);
      chk("mid_rst_done", done, 0);
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || tready) dcnt++;
         tick();
      end
      chk("mid_rst_no_done_or_tready", dcnt, 0);
      tvalid = 1'b0;
      run_vec(tbl[0], 10);
      run_vec(tbl[1], 11);

      // length-0 start after an erroring run: clears results, one done, no beats
      sel = 1'b0; seed = 64'h77; length = 32'd0; start = 1'b1;
      tvalid = 1'b1; tdata = 64'h77;
      tick();
      start = 1'b0;
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      chk("len0_tready", tready, 0);
      chk("len0_counts", {wc, ec}, 0);
      chk("len0_flags", {eflag, tle, fei}, 0);
      chk("len0_fed", fed, 0);
      tick();
      chk("len0_done_low", done, 0);
      chk("len0_no_beats", wc, 0);
      tvalid = 1'b0;

      // reset and start in the same cycle: reset wins
      reset = 1'b1; start = 1'b1; length = 32'd16;
      tick();
      reset = 1'b0; start = 1'b0;
      chk("rst_start_busy", busy, 0);
      tick();
      chk("rst_start_busy2", {busy, tready, done}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mm2s_readback_checker.md
# mm2s_readback_checker

Consumes the 64-bit MM2S read-back stream from the datamover, pacing acceptance to one beat per RATE_DIV cycles to match the downstream Ethernet drain rate. It verifies each beat against the incrementing pattern that the S2MM data generator wrote to DDR3. It also checks tlast placement and reports word and error counts plus a first-error capture. It sits on M_AXIS_MM2S in the top level and replaces the free-running tready divider there.

## Interface
- W, 64, stream data width; tkeep width is W/8
- RATE_DIV, 8, minimum cycles between accepted beats; 1 means tready is held high continuously in RUN
- CNT_W, 32, width of the length input and of all counters
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; loads seed and length and begins a check; honoured only in IDLE
- seed  in  W  expected data of the first beat
- length  in  CNT_W  number of beats expected; tlast is expected on the final beat
- s_axis_tdata  in  W  read-back data
- s_axis_tkeep  in  W/8  byte enables; any value other than all-ones counts as a beat error
- s_axis_tlast  in  1  end-of-transfer marker
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of check
- word_count  out  CNT_W  beats accepted since the last start
- err_count  out  CNT_W  beats that mismatched; saturates at all-ones
- err_flag  out  1  sticky; set if err_count is nonzero or tlast_err is set
- tlast_err  out  1  sticky; tlast arrived early, or was missing on the final beat
- first_err_index  out  CNT_W  beat index (0-based) of the first mismatching beat
- first_err_data  out  W  tdata of the first mismatching beat

## Operation
- States: IDLE, RUN. The done pulse is registered on the RUN->IDLE transition.
- Reset value of all outputs is 0. Reset puts the block in IDLE and clears the pace counter, expected value, and every counter and flag.
- IDLE + start with length != 0:
  - go to RUN
  - load expected <= seed and remaining <= length
  - set pace <= RATE_DIV-1
  - clear word_count, err_count, flags, first_err_index and first_err_data
- IDLE + start with length == 0: clear counters and flags, stay in IDLE, pulse done on the next cycle, accept no beats.
- A start pulse received in RUN is ignored, with no side effects.
- s_axis_tready = (state==RUN) && (pace==0). It is driven from registers only, with no combinational path from tvalid.
- Pace counter:
  - In RUN it decrements while nonzero.
  - It holds at 0 until a handshake occurs, so the source loses no slot while stalled.
  - On a handshake it reloads to RATE_DIV-1.
- A handshake is tvalid && tready. On each handshake:
  - A beat is in error if tdata != expected or tkeep != all-ones.
  - On error, err_count increments with saturation. If this is the first error, capture first_err_index <= word_count and first_err_data <= tdata.
  - expected increments by 1, modulo 2^W, wrapping from all-ones to 0.
  - word_count and remaining are updated.
- The beat is the final beat if remaining==1 or tlast==1.
  - If tlast==1 and remaining>1, set tlast_err (early tlast).
  - If remaining==1 and tlast==0, set tlast_err (missing tlast).
  - A final beat moves the FSM to IDLE, and done pulses.
- Beats with tlast=1 that arrive after done are not accepted, because tready stays 0 in IDLE.
- err_flag = (err_count != 0) || tlast_err, registered.
- All result outputs hold their values in IDLE until the next start.

## Timing
- Start sampled at edge E: busy=1 and pace=RATE_DIV-1 after E. The first tready-high cycle is RATE_DIV-1 cycles later; with RATE_DIV=1 it is the same cycle busy rises.
- With tvalid held high, handshakes occur exactly every RATE_DIV cycles.
- Counters, flags and captures update on the edge that samples the handshake. They are visible in the following cycle.
- Final handshake at edge F: busy=0, tready=0 and done=1 in the cycle after F; done=0 one cycle later.
- Length-0 start at edge E: done=1 in the cycle after E, and busy stays 0.
- Reset asserted in RUN: on the next edge busy=0, tready=0, done=0 and all counters are 0, with no done pulse. A start after reset deasserts behaves normally.
- Reset and start in the same cycle: reset wins.

## Test plan
- RATE_DIV=8, seed=0x10, length=16, source always valid with data 0x10..0x1F and tlast on the 16th beat -> handshakes spaced exactly 8 cycles; word_count=16, err_count=0, err_flag=0, one done pulse.
- Same setup with beat 5 data XOR 1 (0x14) -> err_count=1, first_err_index=5, first_err_data=0x14, err_flag=1, word_count=16.
- length=16 with tlast on beat index 9 -> done after the 10th beat, word_count=10, tlast_err=1; a later tvalid is not accepted.
- seed=0xFFFF_FFFF_FFFF_FFFE, length=4, data FE, FF, 0, 1, RATE_DIV=1 -> tready held high, 4 consecutive handshakes, err_count=0 (wrap checked).
- tvalid dropped for 20 cycles after beat 3 -> tready stays high through the stall, the next beat is accepted in the first cycle tvalid returns, and the following beat is 8 cycles later.
- Reset pulsed after 4 beats of a length-16 run -> next cycle busy=0, tready=0, word_count=0, no done. A start issued during a fresh run is ignored, and length=0 gives done one cycle after start.
